// File: rtl/audio_pkg.sv
// Shared constants and helpers for the serial audio transmitter.
package audio_pkg;

    // Framing selection for audio_i2s_tx.MODE.
    localparam int MODE_I2S = 0;    // LRCK changes one SCLK ahead of the slot MSB
    localparam int MODE_LJ  = 1;    // LRCK changes together with the slot MSB

    // Accumulator width: big enough to hold (acc + step) without overflow,
    // since acc never exceeds modulus-1.
    function automatic int accum_width(input int step, input int modulus);
        return $clog2(step + modulus);
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Fractional MCLK synthesis plus SCLK divider, all on the system clock.
// MCLK toggles whenever the phase accumulator wraps; SCLK is the MSB of a
// counter that advances on MCLK rising edges. sclk_fall marks the clk cycle
// on which SCLK drops, which is where the transmitter updates its outputs.
module audio_clk_gen
    import audio_pkg::*;
#(
    parameter int ACCUM_STEP    = 245760,
    parameter int ACCUM_MOD     = 742500,
    parameter int MCLK_DIV_LOG2 = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_mclk,
    output logic o_sclk,
    output logic o_sclk_fall
);

    localparam int ACC_W = accum_width(ACCUM_STEP, ACCUM_MOD);
    localparam logic [ACC_W-1:0] C_STEP = ACCUM_STEP[ACC_W-1:0];
    localparam logic [ACC_W-1:0] C_MOD  = ACCUM_MOD[ACC_W-1:0];

    if (MCLK_DIV_LOG2 < 1 || MCLK_DIV_LOG2 > 4) begin : g_bad_div
        $error("audio_clk_gen: MCLK_DIV_LOG2 must be within 1..4");
    end
    if (ACCUM_STEP >= ACCUM_MOD) begin : g_bad_ratio
        $error("audio_clk_gen: ACCUM_STEP must be below ACCUM_MOD");
    end

    logic [ACC_W-1:0]         r_acc;
    logic                     r_mclk;
    logic [MCLK_DIV_LOG2-1:0] r_div;

    logic [ACC_W-1:0]         w_acc_sum;
    logic [ACC_W-1:0]         w_acc_next;
    logic                     w_wrap;
    logic                     w_mclk_rise;

    // acc + STEP cannot overflow ACC_W bits because acc stays below MOD.
    assign w_acc_sum   = r_acc + C_STEP;
    assign w_wrap      = (w_acc_sum >= C_MOD);
    assign w_acc_next  = w_wrap ? (w_acc_sum - C_MOD) : w_acc_sum;
    assign w_mclk_rise = w_wrap & ~r_mclk;

    // Phase accumulator and MCLK toggle register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_mclk <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            if (w_wrap) begin
                r_mclk <= ~r_mclk;
            end
        end
    end

    // SCLK divider, advanced once per MCLK rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_mclk_rise) begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_mclk      = r_mclk;
    assign o_sclk      = r_div[MCLK_DIV_LOG2-1];
    assign o_sclk_fall = w_mclk_rise & (&r_div);

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo serial audio transmitter (I2S or left-justified) with a one-pair
// input buffer. All serial outputs are registers on clk and change only on
// the SCLK falling edge so the receiver samples on SCLK rising.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int ACCUM_STEP    = 245760,
    parameter int ACCUM_MOD     = 742500,
    parameter int MCLK_DIV_LOG2 = 2,
    parameter int SAMPLE_W      = 16,
    parameter int SLOT_W        = 32,
    parameter int MODE          = MODE_I2S
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mute,
    output logic                audio_mclk,
    output logic                audio_sclk,
    output logic                audio_lrck,
    output logic                audio_dac,
    output logic                underrun
);

    localparam int FRAME_LEN = 2 * SLOT_W;
    localparam int K_W       = $clog2(FRAME_LEN);
    localparam int FRAME_PAD = 1 << K_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_LEN - 1);

    if (SAMPLE_W < 1 || SAMPLE_W > SLOT_W) begin : g_bad_sample_w
        $error("audio_i2s_tx: SAMPLE_W must be within 1..SLOT_W");
    end
    if (SLOT_W > 32) begin : g_bad_slot_w
        $error("audio_i2s_tx: SLOT_W must not exceed 32");
    end
    if (MODE != MODE_I2S && MODE != MODE_LJ) begin : g_bad_mode
        $error("audio_i2s_tx: MODE must be MODE_I2S or MODE_LJ");
    end

    logic                w_sclk_fall;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      w_k_next;
    logic                w_frame_load;

    logic                r_buf_full;
    logic [SAMPLE_W-1:0] r_buf_l;
    logic [SAMPLE_W-1:0] r_buf_r;
    logic [SAMPLE_W-1:0] r_shift_l;
    logic [SAMPLE_W-1:0] r_shift_r;
    logic                r_lrck;
    logic                r_dac;
    logic                r_underrun;

    logic [SAMPLE_W-1:0] w_load_l;
    logic [SAMPLE_W-1:0] w_load_r;
    logic                w_starve;
    logic                w_accept;
    logic [SAMPLE_W-1:0] w_chan_l;
    logic [SAMPLE_W-1:0] w_chan_r;
    logic [FRAME_PAD-1:0] w_frame_bits;
    logic [FRAME_PAD-1:0] w_lrck_table;

    audio_clk_gen #(
        .ACCUM_STEP    (ACCUM_STEP),
        .ACCUM_MOD     (ACCUM_MOD),
        .MCLK_DIV_LOG2 (MCLK_DIV_LOG2)
    ) u_clk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .o_mclk      (audio_mclk),
        .o_sclk      (audio_sclk),
        .o_sclk_fall (w_sclk_fall)
    );

    assign w_k_next     = (r_k == K_LAST) ? '0 : r_k + 1'b1;
    assign w_frame_load = w_sclk_fall && (r_k == K_LAST);
    assign w_accept     = sample_valid && !r_buf_full && !w_frame_load;

    // Frame source selection: buffered pair, then bypass, else silence.
    always_comb begin
        w_load_l = '0;
        w_load_r = '0;
        w_starve = 1'b0;
        if (r_buf_full) begin
            if (!mute) begin
                w_load_l = r_buf_l;
                w_load_r = r_buf_r;
            end
        end else if (sample_valid) begin
            if (!mute) begin
                w_load_l = sample_l;
                w_load_r = sample_r;
            end
        end else begin
            w_starve = 1'b1;
        end
    end

    // The bit for k=0 must come from the pair being loaded on that same edge.
    assign w_chan_l = w_frame_load ? w_load_l : r_shift_l;
    assign w_chan_r = w_frame_load ? w_load_r : r_shift_r;

    // Map every frame position to its data bit (MSB first, zero padding).
    for (genvar gi = 0; gi < FRAME_PAD; gi++) begin : g_frame_bits
        localparam int SLOT = gi / SLOT_W;
        localparam int POS  = gi % SLOT_W;
        if (gi >= FRAME_LEN || POS >= SAMPLE_W) begin : g_pad
            assign w_frame_bits[gi] = 1'b0;
        end else if (SLOT == 0) begin : g_left
            assign w_frame_bits[gi] = w_chan_l[SAMPLE_W-1-POS];
        end else begin : g_right
            assign w_frame_bits[gi] = w_chan_r[SAMPLE_W-1-POS];
        end
    end

    // LRCK per frame position; I2S looks one position ahead.
    for (genvar gi = 0; gi < FRAME_PAD; gi++) begin : g_lrck_table
        localparam int K_LEAD = (MODE == MODE_LJ) ? gi : (gi + 1) % FRAME_LEN;
        assign w_lrck_table[gi] = (gi < FRAME_LEN) && (K_LEAD >= SLOT_W);
    end

    // Frame position counter and serial output registers, stepped on SCLK fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k    <= K_LAST;
            r_dac  <= 1'b0;
            r_lrck <= 1'b0;
        end else if (w_sclk_fall) begin
            r_k    <= w_k_next;
            r_dac  <= w_frame_bits[w_k_next];
            r_lrck <= w_lrck_table[w_k_next];
        end
    end

    // Shift registers hold the pair being sent for the whole frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (w_frame_load) begin
            r_shift_l <= w_load_l;
            r_shift_r <= w_load_r;
        end
    end

    // One-pair input buffer: drained by a frame load, filled by an accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else if (w_frame_load && r_buf_full) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf_l    <= sample_l;
            r_buf_r    <= sample_r;
        end
    end

    // Single-cycle underrun pulse when a frame starts with nothing to send.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_load && w_starve;
        end
    end

    assign sample_ready = ~r_buf_full;
    assign audio_lrck   = r_lrck;
    assign audio_dac    = r_dac;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: two instances (I2S and left-justified)
// share stimulus; each SCLK rising edge the serial bits are compared with
// hand-derived frame contents.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        mute;

    logic sample_ready, audio_mclk, audio_sclk, audio_lrck, audio_dac, underrun;
    logic lj_ready, lj_mclk, lj_sclk, lj_lrck, lj_dac, lj_underrun;

    always #5 clk = ~clk;

    audio_i2s_tx #(.MODE(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .audio_mclk   (audio_mclk),
        .audio_sclk   (audio_sclk),
        .audio_lrck   (audio_lrck),
        .audio_dac    (audio_dac),
        .underrun     (underrun)
    );

    audio_i2s_tx #(.MODE(1)) dut_lj (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (lj_ready),
        .mute         (mute),
        .audio_mclk   (lj_mclk),
        .audio_sclk   (lj_sclk),
        .audio_lrck   (lj_lrck),
        .audio_dac    (lj_dac),
        .underrun     (lj_underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_under  = 0;
    logic        hs_pending = 1'b0;
    logic [15:0] q_l[$];
    logic [15:0] q_r[$];

    // Cycles with underrun high on the I2S instance.
    always @(negedge clk) begin
        if (underrun === 1'b1) n_under++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One clk of producer activity: advance the queue after a handshake.
    task automatic tick();
        @(negedge clk);
        if (hs_pending) begin
            if (q_l.size() > 0) begin
                sample_l = q_l.pop_front();
                sample_r = q_r.pop_front();
            end else begin
                sample_valid = 1'b0;
            end
        end
        hs_pending = sample_valid && sample_ready;
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        q_l.push_back(l);
        q_r.push_back(r);
        if (!sample_valid) begin
            sample_l     = q_l.pop_front();
            sample_r     = q_r.pop_front();
            sample_valid = 1'b1;
            hs_pending   = sample_ready;
        end
    endtask

    task automatic wait_rise();
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = audio_sclk;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (!prev && audio_sclk) found = 1'b1;
            prev = audio_sclk;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL sclk_timeout: observed no SCLK rise in 200 clk, expected one");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    endtask

    // Read frame positions k_first..k_last and compare both instances.
    task automatic read_frame(input int fr, input logic [15:0] l, input logic [15:0] r,
                              input int k_first, input int k_last, input logic mute_after);
        logic [15:0] ch;
        logic        e_dac, e_lr_i2s, e_lr_lj;
        int          p;
        for (int k = k_first; k <= k_last; k++) begin
            wait_rise();
            p        = k % 32;
            ch       = (k < 32) ? l : r;
            e_dac    = (p < 16) ? ch[15-p] : 1'b0;
            e_lr_i2s = (((k + 1) % 64) >= 32);
            e_lr_lj  = (k >= 32);
            check($sformatf("f%0d k%0d dac", fr, k), audio_dac, e_dac);
            check($sformatf("f%0d k%0d lrck", fr, k), audio_lrck, e_lr_i2s);
            check($sformatf("f%0d k%0d lj_dac", fr, k), lj_dac, e_dac);
            check($sformatf("f%0d k%0d lj_lrck", fr, k), lj_lrck, e_lr_lj);
            if (k == k_first) mute = mute_after;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " mclk"}, audio_mclk, 1'b0);
        check({tag, " sclk"}, audio_sclk, 1'b0);
        check({tag, " lrck"}, audio_lrck, 1'b0);
        check({tag, " dac"}, audio_dac, 1'b0);
        check({tag, " underrun"}, underrun, 1'b0);
        check({tag, " ready"}, sample_ready, 1'b1);
        check({tag, " lj_ready"}, lj_ready, 1'b1);
    endtask

    int   c_mclk, c_sclk, c_lr, c_lr_lj;
    logic p_mclk, p_sclk, p_lr, p_lr_lj;

    initial begin
        reset_n      = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        sample_valid = 1'b0;
        mute         = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");

        // Frame 0: pair offered before the first frame.
        reset_n = 1'b1;
        offer(16'hA5C3, 16'h0F0F);
        wait_rise();
        check("pre-frame dac", audio_dac, 1'b0);
        read_frame(0, 16'hA5C3, 16'h0F0F, 0, 63, 1'b0);
        check("underrun after f0", n_under, 0);

        // Frames 1-2 starve; a pair arrives mid frame 2.
        read_frame(1, 16'h0000, 16'h0000, 0, 63, 1'b0);
        read_frame(2, 16'h0000, 16'h0000, 0, 31, 1'b0);
        offer(16'h1234, 16'h8001);
        read_frame(2, 16'h0000, 16'h0000, 32, 63, 1'b0);
        check("underrun after f2", n_under, 2);

        // Frames 3-6: back-to-back pairs, pair 2 muted.
        read_frame(3, 16'h1234, 16'h8001, 0, 0, 1'b0);
        offer(16'h8000, 16'h0001);
        offer(16'hFFFF, 16'hFFFF);
        offer(16'h5A5A, 16'hC33C);
        tick();
        check("ready after accept", sample_ready, 1'b0);
        read_frame(3, 16'h1234, 16'h8001, 1, 63, 1'b0);
        read_frame(4, 16'h8000, 16'h0001, 0, 63, 1'b1);
        read_frame(5, 16'h0000, 16'h0000, 0, 63, 1'b0);
        read_frame(6, 16'h5A5A, 16'hC33C, 0, 63, 1'b0);
        check("underrun after f6", n_under, 2);
        check("ready after f6", sample_ready, 1'b1);

        // Frame 7 starves, then a pair is buffered and reset hits at k=20.
        read_frame(7, 16'h0000, 16'h0000, 0, 0, 1'b0);
        check("underrun f7", n_under, 3);
        offer(16'h7777, 16'h7777);
        tick();
        check("ready buffered f7", sample_ready, 1'b0);
        read_frame(7, 16'h0000, 16'h0000, 1, 20, 1'b0);
        reset_n = 1'b0;
        #1;
        check_idle("midreset");
        sample_valid = 1'b0;
        hs_pending   = 1'b0;
        q_l.delete();
        q_r.delete();
        repeat (4) @(negedge clk);
        check_idle("midreset hold");
        reset_n = 1'b1;
        wait_rise();
        read_frame(8, 16'h0000, 16'h0000, 0, 63, 1'b0);
        check("underrun after reset", n_under, 4);

        // Rates over 37125 clk (0.5 ms of audio at 74.25 MHz).
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        c_mclk = 0; c_sclk = 0; c_lr = 0; c_lr_lj = 0;
        p_mclk = audio_mclk; p_sclk = audio_sclk; p_lr = audio_lrck; p_lr_lj = lj_lrck;
        for (int i = 0; i < 37125; i++) begin
            @(negedge clk);
            if (!p_mclk && audio_mclk) c_mclk++;
            if (!p_sclk && audio_sclk) c_sclk++;
            if (!p_lr && audio_lrck) c_lr++;
            if (!p_lr_lj && lj_lrck) c_lr_lj++;
            p_mclk = audio_mclk; p_sclk = audio_sclk; p_lr = audio_lrck; p_lr_lj = lj_lrck;
        end
        check_range("mclk rises", c_mclk, 6143, 6145);
        check_range("sclk periods", c_sclk, 1535, 1537);
        check_range("lrck periods", c_lr, 23, 25);
        check_range("lj lrck periods", c_lr_lj, 23, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
